// File: rtl/sd_block_pkg.sv
// Shared types and constants for the emulated SD block-device responder.
package sd_block_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int GAP_CYCLES   = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RD_REQ,
        ST_RD_PUT,
        ST_WR_ADDR,
        ST_WR_WAIT,
        ST_WR_PUT,
        ST_DONE,
        ST_GAP
    } state_t;

    // Backing-store byte address {drive, lba, byte}; callers truncate to their address width.
    function automatic logic [63:0] sector_mem_addr(input logic [3:0]  drive,
                                                    input logic [31:0] lba,
                                                    input logic [8:0]  byte_idx);
        return {19'd0, drive, lba, byte_idx};
    endfunction

endpackage

// File: rtl/sd_block_responder_arbiter.sv
// Fixed-priority one-hot request arbiter: the lowest requesting drive wins, nothing is granted while busy.
module sd_req_arbiter #(
    parameter int VDNUM = 2
) (
    input  logic [VDNUM-1:0] req,
    input  logic             busy,
    output logic [VDNUM-1:0] grant,
    output logic [3:0]       index,
    output logic             valid
);

    // Scan from the top down so the lowest set request is the last one written.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int i = VDNUM - 1; i >= 0; i--) begin
            if (req[i] && !busy) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = 4'(i);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_block_responder.sv
// Responder side of the emulated SD block interface: serves 512-byte sector reads/writes from a byte store.
// Optional build macro SD_BLOCK_TRACE_EN adds a grant trace and per-drive sector counters for simulation.
module sd_block_responder
    import sd_block_pkg::*;
#(
    parameter int VDNUM   = 2,
    parameter int MEM_AW  = 32,
    parameter int DIN_LAT = 1
) (
    input  logic                CLK_VIDEO,
    input  logic                reset,
    input  logic [VDNUM-1:0]    sd_rd,
    input  logic [VDNUM-1:0]    sd_wr,
    input  logic [VDNUM*32-1:0] sd_lba,
    input  logic [VDNUM*8-1:0]  sd_buff_din,
    input  logic [VDNUM*64-1:0] img_size,
    input  logic [VDNUM-1:0]    img_readonly,
    output logic [VDNUM-1:0]    sd_ack,
    output logic [8:0]          sd_buff_addr,
    output logic [7:0]          sd_buff_dout,
    output logic                sd_buff_wr,
    output logic                mem_rd,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_valid,
    output logic                mem_wr,
    output logic [7:0]          mem_wdata,
    input  logic                mem_ready,
    output logic                busy
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]    WAIT_LAST = 8'(DIN_LAT - 1);
    localparam logic [9:0]    LAST_BYTE = 10'(SECTOR_BYTES - 1);

    state_t            state;
    logic [VDNUM-1:0]  gnt;
    logic [3:0]        gnt_index;
    logic              gnt_valid;
    logic [VDNUM-1:0]  ack_sel;
    logic [3:0]        drive;
    logic [31:0]       lba_q;
    logic              op_wr;
    logic              oob;
    logic              ro;
    logic [9:0]        count;
    logic [9:0]        next_count;
    logic [7:0]        wait_cnt;
    logic [GW-1:0]     gap_cnt;

    logic [31:0]       sel_lba;
    logic [63:0]       sel_size;
    logic              sel_ro;
    logic              sel_rd;
    logic              sel_oob;
    logic [40:0]       sel_bytes;
    logic [7:0]        cur_din;

    sd_req_arbiter #(.VDNUM(VDNUM)) u_arbiter (
        .req   (sd_rd | sd_wr),
        .busy  (state != ST_IDLE),
        .grant (gnt),
        .index (gnt_index),
        .valid (gnt_valid)
    );

    // Per-drive fields for the drive being granted now and for the drive already acknowledged.
    always_comb begin
        sel_lba  = '0;
        sel_size = '0;
        sel_ro   = 1'b0;
        sel_rd   = 1'b0;
        cur_din  = '0;
        for (int i = 0; i < VDNUM; i++) begin
            if (gnt[i]) begin
                sel_lba  = sd_lba[32*i +: 32];
                sel_size = img_size[64*i +: 64];
                sel_ro   = img_readonly[i];
                sel_rd   = sd_rd[i];
            end
            if (ack_sel[i]) begin
                cur_din = sd_buff_din[8*i +: 8];
            end
        end
    end

    // Sizes beyond 41 bits can never be reached by a 32-bit LBA, so they are always in range.
    assign sel_bytes  = {sel_lba, 9'd0};
    assign sel_oob    = (sel_size[63:41] == '0) ? (sel_bytes >= sel_size[40:0]) : 1'b0;
    assign next_count = count + 10'd1;

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            state        <= ST_IDLE;
            sd_ack       <= '0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            ack_sel      <= '0;
            drive        <= '0;
            lba_q        <= '0;
            op_wr        <= 1'b0;
            oob          <= 1'b0;
            ro           <= 1'b0;
            count        <= '0;
            wait_cnt     <= '0;
            gap_cnt      <= '0;
        end else begin
            sd_buff_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        ack_sel <= gnt;
                        drive   <= gnt_index;
                        lba_q   <= sel_lba;
                        op_wr   <= !sel_rd;
                        oob     <= sel_oob;
                        ro      <= sel_ro;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    sd_ack <= ack_sel;
                    if (op_wr) begin
                        state <= ST_WR_ADDR;
                    end else begin
                        mem_rd   <= !oob;
                        mem_addr <= MEM_AW'(sector_mem_addr(drive, lba_q, count[8:0]));
                        state    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (oob) begin
                        sd_buff_addr <= count[8:0];
                        sd_buff_dout <= 8'h00;
                        sd_buff_wr   <= 1'b1;
                        state        <= ST_RD_PUT;
                    end else if (mem_valid) begin
                        mem_rd       <= 1'b0;
                        sd_buff_addr <= count[8:0];
                        sd_buff_dout <= mem_rdata;
                        sd_buff_wr   <= 1'b1;
                        state        <= ST_RD_PUT;
                    end
                end
                ST_RD_PUT: begin
                    if (count == LAST_BYTE) begin
                        sd_buff_addr <= '0;
                        state        <= ST_DONE;
                    end else begin
                        count    <= next_count;
                        mem_rd   <= !oob;
                        mem_addr <= MEM_AW'(sector_mem_addr(drive, lba_q, next_count[8:0]));
                        state    <= ST_RD_REQ;
                    end
                end
                ST_WR_ADDR: begin
                    sd_buff_addr <= count[8:0];
                    wait_cnt     <= '0;
                    state        <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_WR_PUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WR_PUT: begin
                    // First cycle samples the initiator byte; protected or out-of-range sectors skip the store.
                    if (!mem_wr && !oob && !ro) begin
                        mem_wdata <= cur_din;
                        mem_addr  <= MEM_AW'(sector_mem_addr(drive, lba_q, count[8:0]));
                        mem_wr    <= 1'b1;
                    end else if (!mem_wr || mem_ready) begin
                        mem_wr <= 1'b0;
                        if (count == LAST_BYTE) begin
                            sd_buff_addr <= '0;
                            state        <= ST_DONE;
                        end else begin
                            count <= next_count;
                            state <= ST_WR_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    sd_ack  <= '0;
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SD_BLOCK_TRACE_EN
    logic [31:0] sector_count [VDNUM];

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            for (int i = 0; i < VDNUM; i++) sector_count[i] <= '0;
        end else if (state == ST_IDLE && gnt_valid) begin
            for (int i = 0; i < VDNUM; i++) begin
                if (gnt[i]) sector_count[i] <= sector_count[i] + 32'd1;
            end
            $display("sd_block: drive %0d %s lba %0d oob %0b", gnt_index, sel_rd ? "rd" : "wr", sel_lba, sel_oob);
        end
    end
`else
    // Trace build only: no sector counters here.
`endif

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder: vector table of single-sector transfers plus multi-cycle sequences.
module tb_sd_block_responder;

    localparam int VDNUM = 2;

    logic                CLK_VIDEO = 1'b0;
    logic                reset;
    logic [VDNUM-1:0]    sd_rd;
    logic [VDNUM-1:0]    sd_wr;
    logic [VDNUM*32-1:0] sd_lba;
    logic [VDNUM*8-1:0]  sd_buff_din = '0;
    logic [VDNUM*64-1:0] img_size;
    logic [VDNUM-1:0]    img_readonly;
    logic [VDNUM-1:0]    sd_ack;
    logic [8:0]          sd_buff_addr;
    logic [7:0]          sd_buff_dout;
    logic                sd_buff_wr;
    logic                mem_rd;
    logic [31:0]         mem_addr;
    logic [7:0]          mem_rdata = '0;
    logic                mem_valid = 1'b0;
    logic                mem_wr;
    logic [7:0]          mem_wdata;
    logic                mem_ready = 1'b0;
    logic                busy;

    sd_block_responder #(.VDNUM(VDNUM), .MEM_AW(32), .DIN_LAT(1)) dut (
        .CLK_VIDEO    (CLK_VIDEO),
        .reset        (reset),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_lba       (sd_lba),
        .sd_buff_din  (sd_buff_din),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .busy         (busy)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    typedef struct {
        int          drive;
        bit          is_wr;
        logic [31:0] lba;
        logic [63:0] size;
        bit          ro;
        int          exp_strobes;
        int          exp_mem_rd;
        int          exp_mem_wr;
        logic [31:0] exp_base;
        bit          exp_zero;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_base = '0;
    bit          exp_zero = 1'b0;
    logic [7:0]  exp_pat  = 8'hA5;

    int          k_rd = 0;
    int          k_mrd = 0;
    int          k_mwr = 0;
    int          bad = 0;
    logic [31:0] cur_base = '0;
    bit          cur_zero = 1'b0;
    logic [7:0]  cur_pat = '0;
    logic [VDNUM-1:0] prev_ack = '0;
    logic [31:0] sector_first[$];

    // Initiator BRAM: registered read, drive 1 holds k^0x5A and drive 0 holds k^0xA5.
    always @(posedge CLK_VIDEO) begin
        sd_buff_din <= {sd_buff_addr[7:0] ^ 8'h5A, sd_buff_addr[7:0] ^ 8'hA5};
    end

    // Byte store (data = addr[7:0], one-cycle handshakes) and transfer monitor, all on the falling edge.
    always @(negedge CLK_VIDEO) begin
        bit hs_rd;
        bit hs_wr;
        hs_rd = mem_rd && !mem_valid;
        hs_wr = mem_wr && !mem_ready;
        if (sd_ack != '0 && prev_ack == '0) begin
            k_rd     = 0;
            k_mrd    = 0;
            k_mwr    = 0;
            bad      = 0;
            cur_base = exp_base;
            cur_zero = exp_zero;
            cur_pat  = exp_pat;
        end
        prev_ack = sd_ack;
        if (sd_buff_wr) begin
            if (sd_ack == '0 || sd_buff_addr != 9'(k_rd) ||
                sd_buff_dout != (cur_zero ? 8'h00 : 8'(cur_base + 32'(k_rd)))) bad++;
            k_rd++;
        end
        if (hs_rd) begin
            if (k_mrd == 0) sector_first.push_back(mem_addr);
            if (mem_addr != cur_base + 32'(k_mrd)) bad++;
            k_mrd++;
        end
        if (hs_wr) begin
            if (mem_addr != cur_base + 32'(k_mwr) || mem_wdata != (8'(k_mwr) ^ cur_pat)) bad++;
            k_mwr++;
        end
        mem_valid = hs_rd;
        mem_rdata = mem_addr[7:0];
        mem_ready = hs_wr;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge CLK_VIDEO);
        sd_lba[32*v.drive +: 32]   = v.lba;
        img_size[64*v.drive +: 64] = v.size;
        img_readonly[v.drive]      = v.ro;
        exp_base = v.exp_base;
        exp_zero = v.exp_zero;
        exp_pat  = (v.drive == 1) ? 8'h5A : 8'hA5;
        if (v.is_wr) sd_wr[v.drive] = 1'b1;
        else         sd_rd[v.drive] = 1'b1;
    endtask

    task automatic waitAck(input bit level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge CLK_VIDEO);
            #1;
            if ((sd_ack != '0) == level) ok = 1'b1;
        end
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge CLK_VIDEO);
            #1;
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic runVector(input int idx);
        vec_t v;
        bit ok;
        logic [VDNUM-1:0] exp_ack;
        v = vecs[idx];
        applyStimulus(v);
        waitAck(1'b1, 10, ok);
        checkOutput($sformatf("v%0d_ack_rise", idx), 64'(ok), 64'd1);
        exp_ack = '0;
        exp_ack[v.drive] = 1'b1;
        checkOutput($sformatf("v%0d_ack_onehot", idx), 64'(sd_ack), 64'(exp_ack));
        sd_rd = '0;
        sd_wr = '0;
        waitAck(1'b0, 4000, ok);
        checkOutput($sformatf("v%0d_ack_fall", idx), 64'(ok), 64'd1);
        checkOutput($sformatf("v%0d_strobes", idx), 64'(k_rd), 64'(v.exp_strobes));
        checkOutput($sformatf("v%0d_mem_rd", idx), 64'(k_mrd), 64'(v.exp_mem_rd));
        checkOutput($sformatf("v%0d_mem_wr", idx), 64'(k_mwr), 64'(v.exp_mem_wr));
        checkOutput($sformatf("v%0d_data_bad", idx), 64'(bad), 64'd0);
        checkOutput($sformatf("v%0d_addr_wrap", idx), 64'(sd_buff_addr), 64'd0);
        waitIdle(ok);
        checkOutput($sformatf("v%0d_idle", idx), 64'(ok), 64'd1);
    endtask

    initial begin
        bit ok;
        int n;
        int bad_total;

        vecs[0] = '{0, 1'b0, 32'd5,          64'h4000_0000,          1'b0, 512, 512, 0,   32'd2560,      1'b0};
        vecs[1] = '{1, 1'b1, 32'd2,          64'h4000_0000,          1'b0, 0,   0,   512, 32'd1024,      1'b0};
        vecs[2] = '{0, 1'b0, 32'd3,          64'd1024,               1'b0, 512, 0,   0,   32'd0,         1'b1};
        vecs[3] = '{1, 1'b1, 32'd2,          64'h4000_0000,          1'b1, 0,   0,   0,   32'd1024,      1'b0};
        vecs[4] = '{0, 1'b0, 32'd1,          64'd1024,               1'b0, 512, 512, 0,   32'd512,       1'b0};
        vecs[5] = '{1, 1'b1, 32'd2,          64'd1024,               1'b0, 0,   0,   0,   32'd1024,      1'b0};
        vecs[6] = '{1, 1'b0, 32'hFFFF_FFFF,  64'h0001_0000_0000_0000, 1'b0, 512, 512, 0,   32'hFFFF_FE00, 1'b0};

        reset        = 1'b1;
        sd_rd        = '0;
        sd_wr        = '0;
        sd_lba       = '0;
        img_size     = '0;
        img_readonly = '0;
        repeat (3) @(posedge CLK_VIDEO);
        #1;
        checkOutput("rst_ack", 64'(sd_ack), 64'd0);
        checkOutput("rst_buff_wr", 64'(sd_buff_wr), 64'd0);
        checkOutput("rst_buff_addr", 64'(sd_buff_addr), 64'd0);
        checkOutput("rst_buff_dout", 64'(sd_buff_dout), 64'd0);
        checkOutput("rst_mem_rd", 64'(mem_rd), 64'd0);
        checkOutput("rst_mem_wr", 64'(mem_wr), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        @(negedge CLK_VIDEO);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) runVector(i);

        // Simultaneous reads on drives 0 and 1: drive 0 first, drive 1 after DONE + 2 GAP + IDLE + GRANT.
        @(negedge CLK_VIDEO);
        sd_lba       = '0;
        img_size     = {64'h4000_0000, 64'h4000_0000};
        img_readonly = '0;
        exp_base     = 32'd0;
        exp_zero     = 1'b0;
        exp_pat      = 8'hA5;
        sd_rd        = 2'b11;
        @(posedge CLK_VIDEO);
        #1;
        checkOutput("prio_latch_ack", 64'(sd_ack), 64'd0);
        checkOutput("prio_latch_busy", 64'(busy), 64'd1);
        @(posedge CLK_VIDEO);
        #1;
        checkOutput("prio_first_ack", 64'(sd_ack), 64'b01);
        sd_rd[0] = 1'b0;
        waitAck(1'b0, 4000, ok);
        checkOutput("prio_first_fall", 64'(ok), 64'd1);
        checkOutput("prio_first_strobes", 64'(k_rd), 64'd512);
        n = 0;
        while (sd_ack == '0 && n < 20) begin
            @(posedge CLK_VIDEO);
            #1;
            n++;
        end
        checkOutput("prio_gap_cycles", 64'(n), 64'd4);
        checkOutput("prio_second_ack", 64'(sd_ack), 64'b10);
        sd_rd = '0;
        waitAck(1'b0, 4000, ok);
        checkOutput("prio_second_fall", 64'(ok), 64'd1);
        checkOutput("prio_second_bad", 64'(bad), 64'd0);
        waitIdle(ok);

        // Held read on drive 0 for 13 sectors, LBA stepped after each ack rise.
        @(negedge CLK_VIDEO);
        sd_lba[31:0] = 32'd26;
        exp_base     = 32'(26 * 512);
        sector_first.delete();
        sd_rd[0]     = 1'b1;
        bad_total    = 0;
        n            = 0;
        for (int s = 0; s < 13; s++) begin
            waitAck(1'b1, 20, ok);
            if (ok) n++;
            @(posedge CLK_VIDEO);
            #1;
            if (s == 12) begin
                sd_rd[0] = 1'b0;
            end else begin
                sd_lba[31:0] = 32'(27 + s);
                exp_base     = 32'((27 + s) * 512);
            end
            waitAck(1'b0, 4000, ok);
            bad_total += bad;
        end
        checkOutput("multi_ack_count", 64'(n), 64'd13);
        checkOutput("multi_sector_count", 64'(sector_first.size()), 64'd13);
        for (int i = 0; i < 13; i++) begin
            checkOutput($sformatf("multi_lba%0d", i), 64'(sector_first[i]), 64'((26 + i) * 512));
        end
        checkOutput("multi_bad", 64'(bad_total), 64'd0);
        repeat (20) @(posedge CLK_VIDEO);
        #1;
        checkOutput("multi_quiet_ack", 64'(sd_ack), 64'd0);
        checkOutput("multi_quiet_busy", 64'(busy), 64'd0);

        // Reset in the middle of a read, then a fresh read starting from byte 0.
        applyStimulus(vecs[0]);
        waitAck(1'b1, 10, ok);
        sd_rd = '0;
        n = 0;
        while (k_rd < 100 && n < 1000) begin
            @(negedge CLK_VIDEO);
            n++;
        end
        checkOutput("rstmid_reached", 64'(k_rd >= 100), 64'd1);
        reset = 1'b1;
        @(posedge CLK_VIDEO);
        #1;
        checkOutput("rstmid_ack", 64'(sd_ack), 64'd0);
        checkOutput("rstmid_buff_wr", 64'(sd_buff_wr), 64'd0);
        checkOutput("rstmid_mem_rd", 64'(mem_rd), 64'd0);
        checkOutput("rstmid_busy", 64'(busy), 64'd0);
        @(negedge CLK_VIDEO);
        reset = 1'b0;
        runVector(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
